multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles waited for mem_ready in any memory state before trap.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 func  input  6  instruction[5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag (Rs-Rt compare).
REQ-007 mem_ready  input  1  memory completes current access this cycle.
REQ-008 PCWr  output  1  PC load enable.
REQ-009 PCSrc  output  2  PC source: 0 PC+4, 1 branch target, 2 jump target.
REQ-010 IRWr  output  1  instruction register load enable.
REQ-011 MemRd  output  1  memory read request.
REQ-012 DmWr  output  1  data memory write request.
REQ-013 RegWr  output  1  register file write enable.
REQ-014 RegDst  output  1  write address: 0 Rd, 1 Rt.
REQ-015 ALUSrc  output  1  ALU B operand: 0 Rt, 1 sign-extended Imm16.
REQ-016 ALUOp  output  3  0 add, 1 subtract; all other codes unused.
REQ-017 MemOut  output  1  writeback data: 0 ALU result, 1 memory data.
REQ-018 state  output  4  current FSM state encoding.
REQ-019 trap  output  1  sticky fault indicator.

Function
REQ-020 States/encoding: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_MEM 7, BRANCH 8, JUMP 9, TRAP 10.
REQ-021 All outputs not asserted by a state SHALL be 0 in that state; outputs are Moore except PCWr/IRWr in FETCH and PCWr in BRANCH.
REQ-022 FETCH: MemRd=1; when mem_ready=1, IRWr=1, PCWr=1, PCSrc=0, next DECODE; else stay.
REQ-023 DECODE (1 cycle, no strobes): opcode 000000 with func 100000 or 100010 -> EXEC_R; 001000 -> EXEC_I; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; any other opcode or R-type func -> TRAP.
REQ-024 EXEC_R: ALUSrc=0, RegDst=0, MemOut=0, RegWr=1, ALUOp=0 for func 100000 else 1; next FETCH.
REQ-025 EXEC_I: ALUSrc=1, ALUOp=0, RegDst=1, MemOut=0, RegWr=1; next FETCH.
REQ-026 MEM_ADDR: ALUSrc=1, ALUOp=0; next MEM_RD if latched opcode 100011, MEM_WR if 101011.
REQ-027 MEM_RD: ALUSrc=1, ALUOp=0, MemRd=1; on mem_ready next WB_MEM.
REQ-028 WB_MEM: RegWr=1, RegDst=1, MemOut=1; next FETCH.
REQ-029 MEM_WR: ALUSrc=1, ALUOp=0, DmWr=1 held until mem_ready; on mem_ready next FETCH.
REQ-030 BRANCH: ALUSrc=0, ALUOp=1, PCSrc=1, PCWr=zero; next FETCH regardless of zero.
REQ-031 JUMP: PCWr=1, PCSrc=2; next FETCH.
REQ-032 Opcode and func SHALL be latched on the FETCH IRWr cycle; later decisions use latched values only.
REQ-033 A 4-bit wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR, increment each cycle mem_ready=0 there; reaching MEM_TIMEOUT with mem_ready=0 -> TRAP.
REQ-034 mem_ready coincident with counter==MEM_TIMEOUT SHALL count as completion, not trap.
REQ-035 TRAP: trap=1, all strobes 0, remain until reset.
REQ-036 mem_ready in a non-memory state SHALL be ignored.

Reset
REQ-037 reset=1 at a clock edge SHALL force state FETCH, wait counter 0, trap 0, latched opcode/func 0, from any state including mid-access and TRAP.
REQ-038 During and immediately after reset, all strobes except MemRd SHALL be 0; MemRd=1 in the first FETCH cycle after reset deasserts.

Verification
REQ-039 add (op 0, func 100000), mem_ready=1 always -> FETCH,DECODE,EXEC_R; RegWr=1, ALUOp=0, RegDst=0 in cycle 3.
REQ-040 lw (100011), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with MemOut=1, RegWr=1, RegDst=1.
REQ-041 beq (000100) with zero=0 then zero=1 -> PCWr 0 then 1 in BRANCH, PCSrc=1, ALUOp=1 both times.
REQ-042 opcode 111111 -> TRAP after DECODE, trap=1 held 20 cycles; reset -> state 0, trap 0.
REQ-043 mem_ready held 0 in FETCH -> TRAP after 16 cycles in FETCH; mem_ready=1 on the 16th cycle -> DECODE instead.
REQ-044 reset asserted during MEM_WR with DmWr=1 -> next cycle state 0, DmWr 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS-subset datapath: fetch/decode/execute sequencing,
// memory handshakes with a bounded wait, and a sticky trap state for faults.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic [1:0] PCSrc,
    output logic       IRWr,
    output logic       MemRd,
    output logic       DmWr,
    output logic       RegWr,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic [2:0] ALUOp,
    output logic       MemOut,
    output logic [3:0] state,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [3:0] TIMEOUT_C = 4'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;
    logic       trap_q;
    logic       mem_state;
    logic       timed_out;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // A ready arriving on the last allowed cycle still completes the access.
    assign timed_out = mem_state && !mem_ready && (wait_q == TIMEOUT_C);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                    op_d    = opcode;
                    fn_d    = func;
                end
            end
            S_DECODE: begin
                state_d = S_TRAP;
                case (op_q)
                    OP_RTYPE:     if (fn_q == FN_ADD || fn_q == FN_SUB) state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      ;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        if (timed_out) state_d = S_TRAP;
    end

    // Counter restarts on every state change, so each memory state sees a fresh budget.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = 4'd0;
        else if (mem_state && !mem_ready)
            wait_d = wait_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= 4'd0;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            trap_q  <= trap_q | (state_d == S_TRAP);
        end
    end

    always_comb begin
        PCWr   = 1'b0;
        PCSrc  = 2'd0;
        IRWr   = 1'b0;
        MemRd  = 1'b0;
        DmWr   = 1'b0;
        RegWr  = 1'b0;
        RegDst = 1'b0;
        ALUSrc = 1'b0;
        ALUOp  = 3'd0;
        MemOut = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRd = 1'b1;
                IRWr  = mem_ready;
                PCWr  = mem_ready;
            end
            S_EXEC_R: begin
                RegWr = 1'b1;
                ALUOp = (fn_q == FN_ADD) ? 3'd0 : 3'd1;
            end
            S_EXEC_I: begin
                ALUSrc = 1'b1;
                RegDst = 1'b1;
                RegWr  = 1'b1;
            end
            S_MEM_ADDR: ALUSrc = 1'b1;
            S_MEM_RD: begin
                ALUSrc = 1'b1;
                MemRd  = 1'b1;
            end
            S_MEM_WR: begin
                ALUSrc = 1'b1;
                DmWr   = 1'b1;
            end
            S_WB_MEM: begin
                RegWr  = 1'b1;
                RegDst = 1'b1;
                MemOut = 1'b1;
            end
            S_BRANCH: begin
                ALUOp = 3'd1;
                PCSrc = 2'd1;
                PCWr  = zero;
            end
            S_JUMP: begin
                PCWr  = 1'b1;
                PCSrc = 2'd2;
            end
            default: ;
        endcase
        // While reset is held nothing may commit; only the fetch read request stays visible.
        if (reset) begin
            PCWr   = 1'b0;
            PCSrc  = 2'd0;
            IRWr   = 1'b0;
            DmWr   = 1'b0;
            RegWr  = 1'b0;
            RegDst = 1'b0;
            ALUSrc = 1'b0;
            ALUOp  = 3'd0;
            MemOut = 1'b0;
        end
    end

    assign state = state_q;
    assign trap  = trap_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cycle table, hand-written corner sequences,
// and random instruction streams checked against an instruction-level expectation model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWr, IRWr, MemRd, DmWr, RegWr, RegDst, ALUSrc, MemOut, trap;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .MemRd(MemRd),
        .DmWr(DmWr), .RegWr(RegWr), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .MemOut(MemOut), .state(state), .trap(trap)
    );

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                           S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6,
                           S_WB_MEM = 4'd7, S_BRANCH = 4'd8, S_JUMP = 4'd9, S_TRAP = 4'd10;

    // Strobe vector: PCWr | PCSrc[1:0] | IRWr | MemRd | DmWr | RegWr | RegDst | ALUSrc | ALUOp[2:0] | MemOut
    localparam logic [12:0] O_NONE = 13'b0_00_0_0_0_0_0_0_000_0;
    localparam logic [12:0] O_FW   = 13'b0_00_0_1_0_0_0_0_000_0;
    localparam logic [12:0] O_FG   = 13'b1_00_1_1_0_0_0_0_000_0;
    localparam logic [12:0] O_ADD  = 13'b0_00_0_0_0_1_0_0_000_0;
    localparam logic [12:0] O_SUB  = 13'b0_00_0_0_0_1_0_0_001_0;
    localparam logic [12:0] O_ADDI = 13'b0_00_0_0_0_1_1_1_000_0;
    localparam logic [12:0] O_MA   = 13'b0_00_0_0_0_0_0_1_000_0;
    localparam logic [12:0] O_MRD  = 13'b0_00_0_1_0_0_0_1_000_0;
    localparam logic [12:0] O_WB   = 13'b0_00_0_0_0_1_1_0_000_1;
    localparam logic [12:0] O_MWR  = 13'b0_00_0_0_1_0_0_1_000_0;
    localparam logic [12:0] O_BR0  = 13'b0_01_0_0_0_0_0_0_001_0;
    localparam logic [12:0] O_BR1  = 13'b1_01_0_0_0_0_0_0_001_0;
    localparam logic [12:0] O_J    = 13'b1_10_0_0_0_0_0_0_000_0;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                           OP_BAD = 6'b111111, FN_ADD = 6'b100000, FN_SUB = 6'b100010;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [12:0] o;
        logic        tr;
    } vec_t;

    vec_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   m_trap = 1'b0;

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [3:0] st,
                        input logic [12:0] o, input logic tr);
        vec_t v;
        v = '{rst, op, fn, z, rdy, st, o, tr};
        q.push_back(v);
    endtask

    task automatic run_queue(input string nm);
        logic [12:0] act;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            reset = q[i].rst; opcode = q[i].op; func = q[i].fn;
            zero = q[i].z; mem_ready = q[i].rdy;
            #1;
            act = {PCWr, PCSrc, IRWr, MemRd, DmWr, RegWr, RegDst, ALUSrc, ALUOp, MemOut};
            total++;
            if (state !== q[i].st || act !== q[i].o || trap !== q[i].tr) begin
                bad++;
                $display("FAIL %s[%0d]: got state=%0d outs=%b trap=%b, expected state=%0d outs=%b trap=%b",
                         nm, i, state, act, trap, q[i].st, q[i].o, q[i].tr);
            end
        end
        q.delete();
    endtask

    // Memory handshake: up to 15 idle cycles are tolerated, the 16th idle cycle traps.
    task automatic mem_phase(input logic [3:0] st, input int waits, input logic [12:0] ow,
                             input logic [12:0] og, input logic [5:0] op, input logic [5:0] fn,
                             input bit real_ir, output bit ok);
        for (int k = 0; k < waits && k < 16; k++)
            push(1'b0, real_ir ? op : r6(), real_ir ? fn : r6(), r1(), 1'b0, st, ow, 1'b0);
        if (waits >= 16) begin
            push(1'b0, r6(), r6(), r1(), r1(), S_TRAP, O_NONE, 1'b1);
            m_trap = 1'b1;
            ok = 1'b0;
        end else begin
            push(1'b0, real_ir ? op : r6(), real_ir ? fn : r6(), r1(), 1'b1, st, og, 1'b0);
            ok = 1'b1;
        end
    endtask

    // Expected cycle trace of one instruction; IR inputs are scrambled after fetch.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                               input int mw, input logic z);
        bit ok;
        mem_phase(S_FETCH, fw, O_FW, O_FG, op, fn, 1'b1, ok);
        if (!ok) return;
        push(1'b0, r6(), r6(), r1(), r1(), S_DECODE, O_NONE, 1'b0);
        if (op == OP_R && fn == FN_ADD)      push(1'b0, r6(), r6(), r1(), r1(), S_EXEC_R, O_ADD, 1'b0);
        else if (op == OP_R && fn == FN_SUB) push(1'b0, r6(), r6(), r1(), r1(), S_EXEC_R, O_SUB, 1'b0);
        else if (op == OP_ADDI)              push(1'b0, r6(), r6(), r1(), r1(), S_EXEC_I, O_ADDI, 1'b0);
        else if (op == OP_LW || op == OP_SW) begin
            push(1'b0, r6(), r6(), r1(), r1(), S_MEM_ADDR, O_MA, 1'b0);
            if (op == OP_LW) begin
                mem_phase(S_MEM_RD, mw, O_MRD, O_MRD, op, fn, 1'b0, ok);
                if (ok) push(1'b0, r6(), r6(), r1(), r1(), S_WB_MEM, O_WB, 1'b0);
            end else
                mem_phase(S_MEM_WR, mw, O_MWR, O_MWR, op, fn, 1'b0, ok);
        end
        else if (op == OP_BEQ) push(1'b0, r6(), r6(), z, r1(), S_BRANCH, z ? O_BR1 : O_BR0, 1'b0);
        else if (op == OP_J)   push(1'b0, r6(), r6(), r1(), r1(), S_JUMP, O_J, 1'b0);
        else begin
            push(1'b0, r6(), r6(), r1(), r1(), S_TRAP, O_NONE, 1'b1);
            m_trap = 1'b1;
        end
    endtask

    function automatic int rwait();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(13, 18));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [5:0] op, fn;
        int fw, mw, sel;
        logic z;

        repeat (2) @(posedge clk);

        // Directed table: reset, add, sub, addi, lw with waits, beq both ways, j, sw + reset, bad op
        push(1, OP_R, FN_ADD, 0, 1, S_FETCH, O_FW, 0);
        push(0, OP_R, FN_ADD, 0, 0, S_FETCH, O_FW, 0);
        push(0, OP_R, FN_ADD, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_BAD, 6'd0, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_BAD, 6'd0, 0, 1, S_EXEC_R, O_ADD, 0);
        push(0, OP_R, FN_SUB, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_R, FN_ADD, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_R, FN_ADD, 0, 1, S_EXEC_R, O_SUB, 0);
        push(0, OP_ADDI, 6'd0, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_LW, 6'd0, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_LW, 6'd0, 0, 1, S_EXEC_I, O_ADDI, 0);
        push(0, OP_LW, 6'd0, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_SW, 6'd0, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_SW, 6'd0, 0, 1, S_MEM_ADDR, O_MA, 0);
        push(0, OP_SW, 6'd0, 0, 0, S_MEM_RD, O_MRD, 0);
        push(0, OP_SW, 6'd0, 0, 0, S_MEM_RD, O_MRD, 0);
        push(0, OP_SW, 6'd0, 0, 0, S_MEM_RD, O_MRD, 0);
        push(0, OP_SW, 6'd0, 0, 1, S_MEM_RD, O_MRD, 0);
        push(0, OP_SW, 6'd0, 0, 0, S_WB_MEM, O_WB, 0);
        push(0, OP_BEQ, 6'd0, 1, 1, S_FETCH, O_FG, 0);
        push(0, OP_J, 6'd0, 1, 1, S_DECODE, O_NONE, 0);
        push(0, OP_J, 6'd0, 0, 1, S_BRANCH, O_BR0, 0);
        push(0, OP_BEQ, 6'd0, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_R, 6'd0, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_R, 6'd0, 1, 1, S_BRANCH, O_BR1, 0);
        push(0, OP_J, 6'd0, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_LW, 6'd0, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_LW, 6'd0, 0, 1, S_JUMP, O_J, 0);
        push(0, OP_SW, 6'd0, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_LW, 6'd0, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_LW, 6'd0, 0, 1, S_MEM_ADDR, O_MA, 0);
        push(0, OP_LW, 6'd0, 0, 0, S_MEM_WR, O_MWR, 0);
        push(1, OP_LW, 6'd0, 0, 0, S_MEM_WR, O_NONE, 0);
        push(0, OP_BAD, 6'd0, 0, 0, S_FETCH, O_FW, 0);
        push(0, OP_BAD, 6'd0, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_R, FN_ADD, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_R, FN_ADD, 0, 1, S_TRAP, O_NONE, 1);
        $display("directed table: %0d cycles", q.size());
        run_queue("table");

        // Trap holds for 20 cycles whatever mem_ready does, then reset clears it
        for (int i = 0; i < 19; i++) push(0, r6(), r6(), r1(), r1(), S_TRAP, O_NONE, 1);
        push(1, r6(), r6(), r1(), 1, S_TRAP, O_NONE, 1);
        $display("trap hold sequence");
        run_queue("trap_hold");

        // Fetch timeout: 16 idle cycles trap; ready on the 16th cycle decodes instead
        for (int i = 0; i < 16; i++) push(0, OP_ADDI, 6'd0, 0, 0, S_FETCH, O_FW, 0);
        push(0, OP_ADDI, 6'd0, 0, 1, S_TRAP, O_NONE, 1);
        push(1, OP_ADDI, 6'd0, 0, 0, S_TRAP, O_NONE, 1);
        for (int i = 0; i < 15; i++) push(0, OP_ADDI, 6'd0, 0, 0, S_FETCH, O_FW, 0);
        push(0, OP_ADDI, 6'd0, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_BAD, 6'd0, 0, 0, S_DECODE, O_NONE, 0);
        push(0, OP_BAD, 6'd0, 0, 0, S_EXEC_I, O_ADDI, 0);
        $display("fetch timeout boundary sequence");
        run_queue("fetch_timeout");

        // Unsupported R-type function traps
        push(0, OP_R, 6'b100101, 0, 1, S_FETCH, O_FG, 0);
        push(0, OP_R, FN_ADD, 0, 1, S_DECODE, O_NONE, 0);
        push(0, OP_R, FN_ADD, 0, 1, S_TRAP, O_NONE, 1);
        push(1, OP_R, FN_ADD, 0, 1, S_TRAP, O_NONE, 1);
        $display("bad func sequence");
        run_queue("bad_func");

        // Random instruction stream
        m_trap = 1'b0;
        for (int t = 0; t < 150; t++) begin
            sel = int'($urandom_range(0, 8));
            fn = r6();
            case (sel)
                0: begin op = OP_R; fn = FN_ADD; end
                1: begin op = OP_R; fn = FN_SUB; end
                2: op = OP_ADDI;
                3: op = OP_LW;
                4: op = OP_SW;
                5: op = OP_BEQ;
                6: op = OP_J;
                7: begin
                    do op = r6();
                    while (op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_SW ||
                           op == OP_BEQ || op == OP_J);
                end
                default: begin
                    op = OP_R;
                    while (fn == FN_ADD || fn == FN_SUB) fn = r6();
                end
            endcase
            fw = rwait();
            mw = rwait();
            z = r1();
            model_instr(op, fn, fw, mw, z);
            if (m_trap) begin
                push(0, r6(), r6(), r1(), r1(), S_TRAP, O_NONE, 1);
                push(1, r6(), r6(), r1(), r1(), S_TRAP, O_NONE, 1);
                m_trap = 1'b0;
            end
            $display("txn %0d op=%b fn=%b fetch_wait=%0d mem_wait=%0d zero=%b cycles=%0d",
                     t, op, fn, fw, mw, z, q.size());
            run_queue("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
